// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-master memory arbiter.
//            Holds the arbiter state enumeration, the master index constants,
//            the default bus widths and the write-enable level.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Default bus widths used by the interface and the arbiter top.
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // Level of m1_we_i that denotes a store.
  localparam logic WRITE_ENABLE = 1'b1;

  // Master indices as seen by the tie-break logic and the last-grant register.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the two requester ports and the RAM port of the memory
//            arbiter.
//   m0_*  : instruction-fetch read port (req, addr -> ack, rdata)
//   m1_*  : load/store port (req, we, addr, wdata -> ack, rdata)
//   ram_* : single-port RAM (we, addr, wdata -> combinational rdata)
// Modports:
//   slave  : the arbiter side
//   master : the requester / RAM-model side
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) ();

  logic              m0_req_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  ram_rdata_i,
    output m0_ack_o, m0_rdata_o,
    output m1_ack_o, m1_rdata_o,
    output ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output m0_req_i, m0_addr_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output ram_rdata_i,
    input  m0_ack_o, m0_rdata_o,
    input  m1_ack_o, m1_rdata_o,
    input  ram_we_o, ram_addr_o, ram_wdata_o
  );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Purpose  : Combinational winner selection between the two masters.
//   i_elig0, i_elig1 : master eligible this cycle
//   i_last_grant     : master granted most recently (M0/M1)
//   o_winner         : index of the winning master (M0/M1); only meaningful
//                      when at least one master is eligible
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the master that was not granted last
//   undefined - ties always go to m1; i_last_grant is ignored
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_elig0,
  input  logic i_elig1,
  input  logic i_last_grant,
  output logic o_winner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for history; keep the port for a uniform shape.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  always_comb begin
    o_winner = M0;
    if (i_elig0 && i_elig1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      o_winner = (i_last_grant == M0) ? M1 : M0;
`else
      o_winner = M1;
`endif
    end else if (i_elig1) begin
      o_winner = M1;
    end else begin
      o_winner = M0;
    end
  end

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates an instruction-fetch master (m0) and a load/store
//            master (m1) onto one single-port RAM with combinational read.
//            Each transfer is IDLE -> GNTk -> IDLE; read data is captured at
//            the end of GNTk and acked in the following cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave (m0_*, m1_*, ram_* signals)
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin tie-break with a last-grant register
//   undefined - m1 wins every tie, no last-grant register
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t            r_state;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_last_grant;
  logic              w_winner;
  logic [ADDR_W-1:0] w_ram_addr;

  // A master whose ack is showing this cycle has just been served; keeping it
  // out of arbitration stops a held request from being serviced twice.
  assign w_elig0 = bus.m0_req_i && !r_m0_ack;
  assign w_elig1 = bus.m1_req_i && !r_m1_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = M0;
`endif

  arb_pick u_arb_pick (
    .i_elig0      (w_elig0),
    .i_elig1      (w_elig1),
    .i_last_grant (w_last_grant),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_grant <= M0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          if (w_elig0 || w_elig1) begin
            r_state <= (w_winner == M1) ? GNT1 : GNT0;
          end
        end
        // A granted transfer always completes, whether or not req is still up.
        GNT0: begin
          r_m0_rdata <= bus.ram_rdata_i;
          r_m0_ack   <= 1'b1;
          r_m1_ack   <= 1'b0;
          r_state    <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          r_last_grant <= M0;
`endif
        end
        GNT1: begin
          // For a store this captures the word as it was before the write.
          r_m1_rdata <= bus.ram_rdata_i;
          r_m1_ack   <= 1'b1;
          r_m0_ack   <= 1'b0;
          r_state    <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          r_last_grant <= M1;
`endif
        end
        default: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Word-aligned address of the granted master; zero while idle.
  always_comb begin
    w_ram_addr = '0;
    case (r_state)
      GNT0:    w_ram_addr = bus.m0_addr_i;
      GNT1:    w_ram_addr = bus.m1_addr_i;
      default: w_ram_addr = '0;
    endcase
    w_ram_addr[1:0] = 2'b00;
  end

  // rst is folded in combinationally so a reset landing in GNT1 never writes.
  assign bus.ram_we_o    = (r_state == GNT1) && (bus.m1_we_i == WRITE_ENABLE) && !rst;
  assign bus.ram_addr_o  = w_ram_addr;
  assign bus.ram_wdata_o = bus.m1_wdata_i;

  assign bus.m0_ack_o   = r_m0_ack;
  assign bus.m1_ack_o   = r_m1_ack;
  assign bus.m0_rdata_o = r_m0_rdata;
  assign bus.m1_rdata_o = r_m1_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A small RAM model sits on the
//            ram_* port; a transfer-level reference model predicts grants,
//            acks and read data and pushes expected acks into a scoreboard
//            queue that a separate monitor drains.
// Build option: MEM_ARB_ROUND_ROBIN_EN (must match the DUT build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM model (64 words, address bits [7:2]) ----------------
  logic [31:0] ram [64];
  logic        bk_we;
  logic [5:0]  bk_idx;
  logic [31:0] bk_data;

  assign bus.ram_rdata_i = ram[bus.ram_addr_o[7:2]];

  always @(posedge clk) begin
    if (bus.ram_we_o)  ram[bus.ram_addr_o[7:2]] <= bus.ram_wdata_o;
    else if (bk_we)    ram[bk_idx] <= bk_data;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          m;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          mdl_owner = -1;     // master currently holding the RAM, -1 none
  bit          mdl_ack [2];
  logic [31:0] mdl_rdata [2];
  int          mdl_last = 0;
  logic [31:0] m_addr;
  logic [31:0] m_word;
  bit          m_e0, m_e1;

  int n_checks = 0;
  int n_err    = 0;

  always @(posedge clk) begin
    cyc++;
    if (bk_we) ref_mem[bk_idx] = bk_data;
    if (rst) begin
      mdl_owner    = -1;
      mdl_ack[0]   = 1'b0;
      mdl_ack[1]   = 1'b0;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
      mdl_last     = 0;
    end else if (mdl_owner >= 0) begin
      m_addr = (mdl_owner == 0) ? bus.m0_addr_i : bus.m1_addr_i;
      m_word = ref_mem[m_addr[7:2]];
      if (mdl_owner == 1 && bus.m1_we_i) ref_mem[m_addr[7:2]] = bus.m1_wdata_i;
      sb_q.push_back('{m: mdl_owner, data: m_word, due: cyc});
      mdl_ack[mdl_owner]     = 1'b1;
      mdl_ack[1 - mdl_owner] = 1'b0;
      mdl_rdata[mdl_owner]   = m_word;
      mdl_last  = mdl_owner;
      mdl_owner = -1;
    end else begin
      m_e0 = bus.m0_req_i && !mdl_ack[0];
      m_e1 = bus.m1_req_i && !mdl_ack[1];
      mdl_ack[0] = 1'b0;
      mdl_ack[1] = 1'b0;
      if (m_e0 && m_e1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        mdl_owner = 1 - mdl_last;
`else
        mdl_owner = 1;
`endif
      end else if (m_e1) mdl_owner = 1;
      else if (m_e0)     mdl_owner = 0;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_addr;
  bit          exp_we;
  exp_t        e;

  always @(negedge clk) begin
    chk(!(bus.m0_ack_o && bus.m1_ack_o), "ack_exclusive",
        {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
    if (bus.m0_ack_o || bus.m1_ack_o) begin
      if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_ack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk((e.m == 1) == bus.m1_ack_o, "ack_master", 32'(bus.m1_ack_o), 32'(e.m));
        chk(e.due == cyc, "ack_latency", 32'(cyc), 32'(e.due));
        chk(((e.m == 1) ? bus.m1_rdata_o : bus.m0_rdata_o) == e.data, "ack_rdata",
            (e.m == 1) ? bus.m1_rdata_o : bus.m0_rdata_o, e.data);
      end
    end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      chk(1'b0, "missing_ack", 32'(cyc), 32'(e.due));
    end
    chk(bus.m0_ack_o == mdl_ack[0], "m0_ack", 32'(bus.m0_ack_o), 32'(mdl_ack[0]));
    chk(bus.m1_ack_o == mdl_ack[1], "m1_ack", 32'(bus.m1_ack_o), 32'(mdl_ack[1]));
    chk(bus.m0_rdata_o == mdl_rdata[0], "m0_rdata_hold", bus.m0_rdata_o, mdl_rdata[0]);
    chk(bus.m1_rdata_o == mdl_rdata[1], "m1_rdata_hold", bus.m1_rdata_o, mdl_rdata[1]);
    exp_we = (mdl_owner == 1) && bus.m1_we_i && !rst;
    chk(bus.ram_we_o == exp_we, "ram_we", 32'(bus.ram_we_o), 32'(exp_we));
    if (mdl_owner >= 0) begin
      exp_addr = (mdl_owner == 0) ? bus.m0_addr_i : bus.m1_addr_i;
      exp_addr = exp_addr & 32'hFFFF_FFFC;
      chk(bus.ram_addr_o == exp_addr, "ram_addr", bus.ram_addr_o, exp_addr);
      if (bus.ram_we_o)
        chk(bus.ram_wdata_o == bus.m1_wdata_i, "ram_wdata", bus.ram_wdata_o, bus.m1_wdata_i);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 255));
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one transfer and hold it until the model shows its ack (bounded).
  task automatic do_xfer(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] data);
    bit done = 1'b0;
    if (k == 0) begin
      bus.m0_addr_i = addr; bus.m0_req_i = 1'b1;
    end else begin
      bus.m1_addr_i = addr; bus.m1_we_i = we; bus.m1_wdata_i = data; bus.m1_req_i = 1'b1;
    end
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      if (mdl_ack[k]) done = 1'b1;
    end
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    step();
  endtask

  task automatic rand_phase(input int cycles, input int pct);
    for (int c = 0; c < cycles; c++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (mdl_owner == 0) begin
        if ($urandom_range(0, 3) == 0) bus.m0_req_i = 1'b0;
      end else if (bus.m0_req_i && !mdl_ack[0]) begin
        if ($urandom_range(0, 31) == 0) bus.m0_req_i = 1'b0;
      end else begin
        bus.m0_req_i  = ($urandom_range(0, 99) < pct);
        bus.m0_addr_i = rnd_addr();
      end
      if (mdl_owner == 1) begin
        if ($urandom_range(0, 3) == 0) bus.m1_req_i = 1'b0;
      end else if (bus.m1_req_i && !mdl_ack[1]) begin
        if ($urandom_range(0, 31) == 0) bus.m1_req_i = 1'b0;
      end else begin
        bus.m1_req_i   = ($urandom_range(0, 99) < pct);
        bus.m1_addr_i  = rnd_addr();
        bus.m1_we_i    = 1'($urandom_range(0, 1));
        bus.m1_wdata_i = $urandom;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bk_we = 1'b0; bk_idx = '0; bk_data = '0;
    bus.m0_req_i = 1'b0; bus.m0_addr_i = '0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
    for (int i = 0; i < 64; i++) begin
      step();
      bk_we = 1'b1; bk_idx = 6'(i); bk_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
    end
    step();
    bk_we = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Read of a known word, then store / load back, then a misaligned store.
    do_xfer(0, 1'b0, 32'h0000_0010, 32'h0);
    do_xfer(1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    do_xfer(1, 1'b0, 32'h0000_0020, 32'h0);
    do_xfer(1, 1'b1, 32'h0000_0023, 32'hCAFE_F00D);
    do_xfer(0, 1'b0, 32'h0000_0022, 32'h0);

    // Reset landing in the GNT1 cycle of a store.
    bus.m1_addr_i = 32'h0000_0030; bus.m1_we_i = 1'b1;
    bus.m1_wdata_i = 32'hA5A5_5A5A; bus.m1_req_i = 1'b1;
    for (int i = 0; i < 4 && mdl_owner != 1; i++) step();
    rst = 1'b1; bus.m1_req_i = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    do_xfer(1, 1'b0, 32'h0000_0030, 32'h0);

    // Request dropped once granted: still acked, never re-granted.
    bus.m0_addr_i = 32'h0000_0044; bus.m0_req_i = 1'b1;
    for (int i = 0; i < 4 && mdl_owner != 0; i++) step();
    bus.m0_req_i = 1'b0;
    repeat (4) step();

    // Both masters holding requests continuously.
    bus.m0_addr_i = 32'h0000_0010; bus.m1_addr_i = 32'h0000_0020; bus.m1_we_i = 1'b0;
    bus.m0_req_i = 1'b1; bus.m1_req_i = 1'b1;
    repeat (20) step();
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
    repeat (3) step();

    rand_phase(1500, 30);
    rand_phase(1500, 90);

    rst = 1'b0;
    bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0;
    repeat (6) step();
    chk(sb_q.size() == 0, "scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
